spi_byte_master: RTL

//   SPI mode-0 master for one byte; the byte engine beneath the joystick transfer controller.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_sclk_div.sv | 35 +++
 rtl/spi_byte_master.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_pkg: state encoding, SPI mode constants and parameter defaults.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT_LO = 2'd1,
    ST_SHIFT_HI = 2'd2,
    ST_GAP      = 2'd3
  } spi_state_t;

  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

  localparam int DEFAULT_CLK_DIV    = 4;
  localparam int DEFAULT_GAP_CYCLES = 16;

endpackage
`default_nettype wire

// File: rtl/spi_sclk_div.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_sclk_div: SCLK half-period counter with one-cycle terminal strobe.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module spi_sclk_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tc
);

  localparam logic [7:0] C_LAST = 8'(DIV - 1);

  logic [7:0] r_cnt;
  logic       w_last;

  assign w_last = (r_cnt == C_LAST);
  assign o_tc   = i_en && w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (i_clr || o_tc) begin
      r_cnt <= 8'd0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_byte_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_byte_master: SPI mode-0 single-byte master (MSB first).          |
// | Optional inter-byte gap: define SPI_BYTE_GAP_EN.       Rev 1.0       |
// +----------------------------------------------------------------------+
module spi_byte_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       sndRec,
  input  logic [7:0] DIN,
  input  logic       MISO,
  output logic       BUSY,
  output logic [7:0] DOUT,
  output logic       MOSI,
  output logic       SCLK
);

`ifdef SPI_BYTE_GAP_EN
  localparam spi_state_t C_END_STATE = ST_GAP;
`else
  localparam spi_state_t C_END_STATE = ST_IDLE;
`endif

  spi_state_t r_state;
  spi_state_t w_next;
  logic [6:0] r_tx;
  logic [7:0] r_rx;
  logic [2:0] r_bit_cnt;
  logic       r_busy;
  logic [7:0] r_dout;
  logic       r_mosi;
  logic       r_sclk;
  logic       w_start;
  logic       w_div_en;
  logic       w_tc;
  logic       w_last_bit;

  assign w_start    = (r_state == ST_IDLE) && sndRec;
  assign w_div_en   = (r_state == ST_SHIFT_LO) || (r_state == ST_SHIFT_HI);
  assign w_last_bit = (r_bit_cnt == 3'd7);

  spi_sclk_div #(
    .DIV (CLK_DIV)
  ) u_div (
    .clk   (CLK),
    .rst_n (RST),
    .i_en  (w_div_en),
    .i_clr (w_start),
    .o_tc  (w_tc)
  );

`ifdef SPI_BYTE_GAP_EN
  localparam logic [15:0] C_GAP_LAST = 16'(GAP_CYCLES - 1);
  logic [15:0] r_gap_cnt;
  logic        w_gap_done;

  assign w_gap_done = (r_state == ST_GAP) && (r_gap_cnt == C_GAP_LAST);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_gap_cnt <= 16'd0;
    end else if (r_state != ST_GAP) begin
      r_gap_cnt <= 16'd0;
    end else begin
      r_gap_cnt <= r_gap_cnt + 16'd1;
    end
  end
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_start) w_next = ST_SHIFT_LO;
      ST_SHIFT_LO: if (w_tc) w_next = ST_SHIFT_HI;
      ST_SHIFT_HI: if (w_tc) w_next = w_last_bit ? C_END_STATE : ST_SHIFT_LO;
`ifdef SPI_BYTE_GAP_EN
      ST_GAP:      if (w_gap_done) w_next = ST_IDLE;
`endif
      default:     w_next = ST_IDLE;
    endcase
  end

  // rx samples on the rising SCLK edge; tx advances on the falling edge
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_tx      <= 7'd0;
      r_rx      <= 8'd0;
      r_bit_cnt <= 3'd0;
      r_busy    <= 1'b0;
      r_dout    <= 8'd0;
      r_mosi    <= 1'b0;
      r_sclk    <= CPOL;
    end else begin
      if (w_start) begin
        r_tx      <= DIN[6:0];
        r_mosi    <= DIN[7];
        r_busy    <= 1'b1;
        r_bit_cnt <= 3'd0;
      end
      if (w_tc && (r_state == ST_SHIFT_LO)) begin
        r_sclk <= ~CPOL;
        r_rx   <= {r_rx[6:0], MISO};
      end
      if (w_tc && (r_state == ST_SHIFT_HI)) begin
        r_sclk <= CPOL;
        if (!w_last_bit) begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          r_mosi    <= r_tx[6];
          r_tx      <= {r_tx[5:0], 1'b0};
        end else begin
          r_dout <= r_rx;
          r_mosi <= 1'b0;
`ifndef SPI_BYTE_GAP_EN
          r_busy <= 1'b0;
`endif
        end
      end
`ifdef SPI_BYTE_GAP_EN
      if (w_gap_done) r_busy <= 1'b0;
`endif
    end
  end

  assign BUSY = r_busy;
  assign DOUT = r_dout;
  assign MOSI = r_mosi;
  assign SCLK = r_sclk;

endmodule
`default_nettype wire
